// File: rtl/fpu_sp_divider_nr.sv
// IEEE-754 single-precision divider: Newton-Raphson reciprocal, then one multiply by the dividend.
// Define FPU_DIV_EARLY_EXIT_EN to send special-case operands from INIT straight to DONE.
module fpu_sp_divider_nr #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITERS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             div_by_zero
);
    typedef enum logic [2:0] {
        StIdle, StInit, StMulA, StMulB, StFinal, StNorm, StDone
    } state_e;

    // Fixed-point constants are unsigned Q2.30.
    localparam logic [31:0] Seed48   = 32'hB4B4_B4B5;
    localparam logic [31:0] Seed32   = 32'h7878_7878;
    localparam logic [31:0] Two      = 32'h8000_0000;
    localparam logic [31:0] QNan     = 32'h7FC0_0000;
    localparam logic [2:0]  LastIter = 3'(ITERS - 1);

    state_e state_q, state_d;
    logic [2:0] iter_q, iter_d;

    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [31:0] d_q, x_q, t_q, d_init;
    logic [55:0] q_q, q_prod;
    logic [63:0] seed_prod, dx_prod, xt_prod;
    logic dbz_q;

    logic [7:0] a_exp, b_exp;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic sign, special, special_dbz, q_hi;
    logic [31:0] special_result, norm_result;
    logic [22:0] mant;
    logic signed [9:0] exp_calc;

    assign a_exp  = a_q[30:23];
    assign b_exp  = b_q[30:23];
    // Denormals (exp 0) are treated as zero.
    assign a_zero = (a_exp == 8'd0);
    assign b_zero = (b_exp == 8'd0);
    assign a_inf  = (a_exp == 8'hFF) && (a_q[22:0] == 23'd0);
    assign b_inf  = (b_exp == 8'hFF) && (b_q[22:0] == 23'd0);
    assign a_nan  = (a_exp == 8'hFF) && (a_q[22:0] != 23'd0);
    assign b_nan  = (b_exp == 8'hFF) && (b_q[22:0] != 23'd0);
    assign sign   = a_q[31] ^ b_q[31];
    assign special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

    always_comb begin
        special_result = {sign, 31'd0};
        special_dbz    = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special_result = QNan;
        end else if (b_zero) begin
            special_result = {sign, 8'hFF, 23'd0};
            special_dbz    = ~a_inf;
        end else if (a_inf) begin
            special_result = {sign, 8'hFF, 23'd0};
        end
    end

    // D is the divisor mantissa halved into [0.5,1); all products truncate back to Q2.30.
    assign d_init    = {2'b00, 1'b1, b_q[22:0], 6'd0};
    assign seed_prod = 64'(Seed32) * 64'(d_init);
    assign dx_prod   = 64'(d_q) * 64'(x_q);
    assign xt_prod   = 64'(x_q) * 64'(Two - t_q);
    assign q_prod    = 56'({1'b1, a_q[22:0]}) * 56'(x_q);

    // q_q is Q3.53 and holds 2*a_m/b_m in [1,4).
    assign q_hi     = q_q[54];
    assign mant     = q_hi ? 23'(q_q >> 31) : 23'(q_q >> 30);
    assign exp_calc = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127
                    - $signed({9'd0, ~q_hi});

    always_comb begin
        if (exp_calc > 10'sd254) begin
            norm_result = {sign, 8'hFF, 23'd0};
        end else if (exp_calc < 10'sd1) begin
            norm_result = {sign, 31'd0};
        end else begin
            norm_result = {sign, exp_calc[7:0], mant};
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            StIdle:  if (in_valid) state_d = StInit;
            StInit: begin
                iter_d  = 3'd0;
                state_d = StMulA;
`ifdef FPU_DIV_EARLY_EXIT_EN
                if (special) state_d = StDone;
`endif
            end
            StMulA:  state_d = StMulB;
            StMulB: begin
                if (iter_q == LastIter) begin
                    state_d = StFinal;
                end else begin
                    iter_d  = iter_q + 3'd1;
                    state_d = StMulA;
                end
            end
            StFinal: state_d = StNorm;
            StNorm:  state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            iter_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            x_q      <= '0;
            t_q      <= '0;
            q_q      <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        dbz_q <= 1'b0;
                    end
                end
                StInit: begin
                    d_q <= d_init;
                    x_q <= Seed48 - 32'(seed_prod >> 30);
`ifdef FPU_DIV_EARLY_EXIT_EN
                    if (special) begin
                        result_q <= special_result;
                        dbz_q    <= special_dbz;
                    end
`endif
                end
                StMulA:  t_q <= 32'(dx_prod >> 30);
                StMulB:  x_q <= 32'(xt_prod >> 30);
                StFinal: q_q <= q_prod;
                StNorm: begin
                    result_q <= special ? special_result : norm_result;
                    dbz_q    <= special & special_dbz;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fpu_sp_divider_nr.sv
// Directed bench for fpu_sp_divider_nr with a queue-based scoreboard of expected results.
module tb_fpu_sp_divider_nr;
    localparam int Iters = 3;
    // Latencies count the accepting edge as edge 1.
    localparam int Lat = 2 * Iters + 4;
`ifdef FPU_DIV_EARLY_EXIT_EN
    localparam int LatSp = 2;
`else
    localparam int LatSp = Lat;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b, result;
    logic        in_valid, in_ready, out_valid, out_ready, div_by_zero;

    typedef struct {
        logic [31:0] res;
        int          lo;
        int          hi;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    fpu_sp_divider_nr #(.WIDTH(32), .ITERS(Iters)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .result      (result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_range(input string tag, input logic [31:0] obs,
                             input logic [31:0] lo_v, input logic [31:0] hi_v);
        tests++;
        assert (obs >= lo_v && obs <= hi_v) else begin
            fails++;
            $error("FAIL %s: got %h expected %h..%h", tag, obs, lo_v, hi_v);
        end
    endtask

    // Called #1 after an edge with the DUT idle.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eres, input int lo, input int hi,
                          input logic edbz, input int elat);
        int   n;
        exp_t e;
        chk({tag, "_ready_before"}, {31'd0, in_ready}, 32'd1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back('{eres, lo, hi, edbz});
        chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'(elat));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk_range({tag, "_result"}, result, e.res - 32'(e.lo), e.res + 32'(e.hi));
            chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
        end
        if (out_ready) begin
            @(posedge clk);
            #1;
            chk({tag, "_released"}, {30'd0, out_valid, in_ready}, 32'b01);
        end
    endtask

    initial begin
        logic [31:0] held;
        int          stale;
        rst = 1'b1;
        a = '0;
        b = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_ready", {31'd0, in_ready}, 32'd1);

        run_op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 1, 0, 1'b0, Lat);
        run_op("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1, 1, 1'b0, Lat);
        run_op("neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 0, 0, 1'b1, LatSp);
        run_op("dbz_cleared", 32'hC0F00000, 32'h40200000, 32'hC0400000, 1, 0, 1'b0, Lat);
        run_op("nan_in", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 0, 0, 1'b0, LatSp);
        run_op("zero_zero", 32'h80000000, 32'h00000000, 32'h7FC00000, 0, 0, 1'b0, LatSp);
        run_op("inf_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 0, 0, 1'b0, LatSp);
        run_op("inf_fin", 32'h7F800000, 32'hC0000000, 32'hFF800000, 0, 0, 1'b0, LatSp);
        run_op("inf_zero", 32'h7F800000, 32'h00000000, 32'h7F800000, 0, 0, 1'b0, LatSp);
        run_op("zero_fin", 32'h00000000, 32'h40A00000, 32'h00000000, 0, 0, 1'b0, LatSp);
        run_op("fin_inf", 32'hC0A00000, 32'h7F800000, 32'h80000000, 0, 0, 1'b0, LatSp);
        run_op("denorm_a", 32'h00000001, 32'h3F800000, 32'h00000000, 0, 0, 1'b0, LatSp);
        run_op("denorm_b", 32'h3F800000, 32'h80000001, 32'hFF800000, 0, 0, 1'b1, LatSp);
        run_op("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, 0, 0, 1'b0, Lat);
        run_op("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 0, 0, 1'b0, Lat);
        run_op("max_exp", 32'h7F000000, 32'h3F800000, 32'h7F000000, 1, 0, 1'b0, Lat);

        // Consumer stalls in DONE while new requests are offered.
        out_ready = 1'b0;
        run_op("hold", 32'h40400000, 32'h3FC00000, 32'h40000000, 1, 0, 1'b0, Lat);
        held = result;
        for (int i = 0; i < 5; i++) begin
            a = $urandom;
            b = $urandom;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_result", result, held);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_release", {30'd0, out_valid, in_ready}, 32'b01);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_ignored", {30'd0, out_valid, in_ready}, 32'b01);

        // Reset during MUL_B of the second iteration (fifth edge counting the accept).
        a = 32'h41200000;
        b = 32'h40A00000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd1);
        #1;
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) stale++;
        end
        chk("midrst_no_stale", 32'(stale), 32'd0);
        run_op("after_rst", 32'h41200000, 32'h40A00000, 32'h40000000, 1, 0, 1'b0, Lat);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
